// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code conversion arbiter: direction codes,
// output-stage state encoding and the default code word width.
package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic DIR_B2G = 1'b0;
    localparam logic DIR_G2B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/gray_xcode.sv
// Combinational binary<->Gray transcoder; dir selects the direction.
module gray_xcode
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;

    assign b2g = din ^ (din >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it, which avoids
    // a bit-to-bit dependency chain inside the block.
    always_comb begin
        g2b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            g2b[i] = ^(din >> i);
        end
    end

    assign dout = (dir == DIR_G2B) ? g2b : b2g;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a shared Gray transcoder with a
// one-entry registered output stage and a consumed-result counter.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_dir,
    output logic [CNT_W-1:0] conv_count
);

    out_state_t       state;
    logic             last_grant;
    logic             accept_en;
    logic             win1;
    logic             accept;
    logic [WIDTH-1:0] mux_data;
    logic             mux_dir;
    logic [WIDTH-1:0] xc_data;

    assign out_valid = (state == FULL);
    assign accept_en = !out_valid || out_ready;

    // Requester 1 wins when alone, or on contention when requester 0 went last.
    assign win1   = req1_valid && (!req0_valid || !last_grant);
    assign accept = accept_en && (req0_valid || req1_valid);

    assign req0_ready = accept && !win1;
    assign req1_ready = accept && win1;

    assign mux_data = win1 ? req1_data : req0_data;
    assign mux_dir  = win1 ? req1_dir  : req0_dir;

    gray_xcode #(
        .WIDTH(WIDTH)
    ) u_xcode (
        .din (mux_data),
        .dir (mux_dir),
        .dout(xc_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_id     <= 1'b0;
            out_dir    <= 1'b0;
            conv_count <= '0;
            last_grant <= 1'b1;
        end else begin
            if (out_valid && out_ready) begin
                conv_count <= conv_count + CNT_W'(1);
            end
            if (accept) begin
                state      <= FULL;
                out_data   <= xc_data;
                out_id     <= win1;
                out_dir    <= mux_dir;
                last_grant <= win1;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomised and directed scoreboard bench for gray_conv_arbiter.
module tb_gray_conv_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_dir;
    logic [W-1:0] req0_data;
    logic         req1_valid, req1_ready, req1_dir;
    logic [W-1:0] req1_data;
    logic         out_valid, out_ready, out_id, out_dir;
    logic [W-1:0] out_data;
    logic [CNT_W-1:0] conv_count;

    typedef struct {
        logic [W-1:0] data;
        logic         id;
        logic         dir;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_full = 0;
    int m_cnt  = 0;
    int m_last = 1;

    int b2g_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    gray_conv_arbiter #(
        .WIDTH(W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_data (req0_data),
        .req0_dir  (req0_dir),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_data (req1_data),
        .req1_dir  (req1_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_dir   (out_dir),
        .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int ref_conv(input int x, input int dir);
        int r;
        int s;
        if (dir == 0) return x ^ (x >> 1);
        r = x;
        s = x >> 1;
        while (s != 0) begin
            r = r ^ s;
            s = s >> 1;
        end
        return r;
    endfunction

    // Model: predicts handshakes and counter, issues expected results.
    always @(negedge clk) begin
        int en, w, acc;
        exp_t e;
        if (!rst_n) begin
            m_full = 0;
            m_cnt  = 0;
            m_last = 1;
        end else begin
            check("out_valid", int'(out_valid), m_full);
            check("conv_count", int'(conv_count), m_cnt);
            en = (m_full == 0 || out_ready) ? 1 : 0;
            if (req0_valid && req1_valid) w = 1 - m_last;
            else if (req1_valid)          w = 1;
            else                          w = 0;
            acc = (en != 0 && (req0_valid || req1_valid)) ? 1 : 0;
            check("req0_ready", int'(req0_ready), (acc != 0 && w == 0) ? 1 : 0);
            check("req1_ready", int'(req1_ready), (acc != 0 && w == 1) ? 1 : 0);
            if (m_full != 0 && out_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (acc != 0) begin
                e.id   = w[0];
                e.dir  = (w == 1) ? req1_dir : req0_dir;
                e.data = W'(ref_conv(int'((w == 1) ? req1_data : req0_data), int'(e.dir)));
                sb.push_back(e);
                m_last = w;
                m_full = 1;
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: compares each consumed result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                check("out_data", int'(out_data), int'(e.data));
                check("out_id", int'(out_id), int'(e.id));
                check("out_dir", int'(out_dir), int'(e.dir));
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = '0; req0_dir = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_dir = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        idle_inputs();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_id", int'(out_id), 0);
        check("rst_out_dir", int'(out_dir), 0);
        check("rst_conv_count", int'(conv_count), 0);
        rst_n = 1'b1;

        // Exhaustive transform through requester 0
        out_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_dir   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req0_data = W'(i);
            @(posedge clk); #1;
            check("b2g_table", int'(out_data), b2g_tab[i]);
        end
        req0_dir = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = W'(b2g_tab[i]);
            req0_data = v;
            @(posedge clk); #1;
            check("g2b_table", int'(out_data), i);
        end
        idle_inputs();
        repeat (2) @(posedge clk); #1;

        // Contention: 5 -> 7 (id0), A -> C (id1)
        req0_valid = 1'b1; req0_data = 4'h5; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 4'hA; req1_dir = 1'b1;
        repeat (6) @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk); #1;

        // Backpressure: 9 -> D held for 3 stalled cycles
        req0_valid = 1'b1; req0_data = 4'h9; req0_dir = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        req1_valid = 1'b1; req1_data = 4'h3;
        out_ready  = 1'b0;
        repeat (3) begin
            check("stall_hold", int'(out_data), 'hD);
            @(posedge clk); #1;
        end
        check("stall_hold", int'(out_data), 'hD);
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk); #1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data  = W'($urandom);
            req1_data  = W'($urandom);
            req0_dir   = 1'($urandom);
            req1_dir   = 1'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end

        // Asynchronous reset while full and stalled
        req0_valid = 1'b1; req0_data = 4'h6; req0_dir = 1'b0;
        idle_inputs();
        req0_valid = 1'b1; req0_data = 4'h6;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_count", int'(conv_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 4'h5; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 4'hA; req1_dir = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        check("post_rst_first_id", int'(out_id), 0);
        repeat (4) @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk); #1;

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: code word width in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the conversion counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has a word to convert.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-007 req0_data  input  WIDTH  requester 0 source word.
REQ-008 req0_dir  input  1  requester 0 direction: 0 = binary-to-Gray, 1 = Gray-to-binary.
REQ-009 req1_valid, req1_ready, req1_data, req1_dir  same directions/widths/meanings as requester 0, for requester 1.
REQ-010 out_valid  output  1  out_data holds a converted result.
REQ-011 out_ready  input  1  downstream consumes the result when high with out_valid.
REQ-012 out_data  output  WIDTH  converted word.
REQ-013 out_id  output  1  index of the requester that owns out_data.
REQ-014 out_dir  output  1  direction used for out_data.
REQ-015 conv_count  output  CNT_W  number of results consumed since reset; wraps modulo 2^CNT_W.

Function
REQ-016 Binary-to-Gray SHALL be g = b XOR (b >> 1).
REQ-017 Gray-to-binary SHALL be b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-018 Accept enable SHALL be (!out_valid) OR out_ready; no request is accepted while it is low.
REQ-019 Only one requester SHALL be granted per cycle; at most one of req0_ready/req1_ready is high.
REQ-020 reqN_ready SHALL be high only when accept enable is high, reqN_valid is high, and reqN wins arbitration; ready depends combinationally on valid.
REQ-021 Arbitration SHALL be round-robin on a 1-bit last_grant register: when one requester is valid, it wins; when both are valid, the requester not equal to last_grant wins.
REQ-022 last_grant SHALL update to the winner only on an accepted transfer.
REQ-023 Latency SHALL be exactly 1 cycle: a word accepted at edge k appears on out_data/out_id/out_dir with out_valid high after edge k.
REQ-024 While out_valid is high and out_ready is low, out_data, out_id, out_dir SHALL hold stable.
REQ-025 Simultaneous drain and accept in the same cycle SHALL load the new result, giving full throughput of one word per cycle.
REQ-026 If out_valid and out_ready are high and no request is accepted, out_valid SHALL fall after the edge; out_data keeps its last value.
REQ-027 conv_count SHALL increment by 1 on each cycle with out_valid AND out_ready; 2^CNT_W-1 wraps to 0.
REQ-028 Output state SHALL be a two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on accept or stall.

Reset
REQ-029 On rst_n low, asynchronously: out_valid=0, out_data=0, out_id=0, out_dir=0, conv_count=0, last_grant=1 (so requester 0 wins the first contention), FSM=EMPTY.
REQ-030 Reset mid-operation SHALL discard any held result; no transfer completes in a cycle where rst_n is low.
REQ-031 After rst_n rises, the first edge SHALL be able to accept a request.

Structure
REQ-032 Shared package gray_pkg SHALL hold DIR_B2G=0, DIR_G2B=1, the FSM state encoding EMPTY/FULL, and the default WIDTH.
REQ-033 Conversion logic SHALL be one combinational sub-module, gray_xcode (ports: data in, dir, data out; parameter WIDTH), instantiated once after the arbitration mux.

Verification
REQ-034 Exhaustive transform: requester 0 only, out_ready=1, dir=0 with b=0..15 -> out_data = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; dir=1 with the same Gray values -> out_data = 0..15.
REQ-035 Contention after reset: both valid every cycle, req0_data=4'h5 dir 0, req1_data=4'hA dir 1, out_ready=1 -> grants alternate 0,1,0,1; out stream 4'h7/id0, 4'hC/id1, repeating.
REQ-036 Backpressure: accept 4'h9 dir 0, then out_ready=0 for 3 cycles -> out_data=4'hD held stable, both readies low; out_ready=1 -> result consumed once, conv_count +1.
REQ-037 Back-to-back drain plus accept: out_ready=1 with a result pending and req1_valid=1 -> req1_ready=1 in that cycle; no bubble on out_valid.
REQ-038 Counter wrap with CNT_W=2: 5 consumed results -> conv_count = 1,2,3,0,1.
REQ-039 Async reset while FULL and stalled: rst_n low mid-cycle -> out_valid=0, conv_count=0 immediately, without waiting for a clock edge; first post-reset contention grants requester 0.
